// File: rtl/button_led_ctrl_if.sv
// Button/LED channel bundle: raw buttons and mode in, press pulses, levels and LEDs out.
interface button_led_ctrl_if #(
  parameter int unsigned NUM_CH = 2
);
  logic [NUM_CH-1:0] i_BUT;
  logic [1:0]        i_MODE;
  logic [NUM_CH-1:0] o_PRESS;
  logic [NUM_CH-1:0] o_STATE;
  logic [NUM_CH-1:0] o_LED;

  modport master (
    output i_BUT,
    output i_MODE,
    input  o_PRESS,
    input  o_STATE,
    input  o_LED
  );

  modport slave (
    input  i_BUT,
    input  i_MODE,
    output o_PRESS,
    output o_STATE,
    output o_LED
  );
endinterface

// File: rtl/button_led_ctrl.sv
// Multi-channel button front end (sync, debounce, press detect) driving a
// mode-selected LED controller: toggle, momentary, blink or exclusive select.
module button_led_ctrl #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BLINK_CYCLES    = 6250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic               CLK,
  input logic               RST_N,
  button_led_ctrl_if.slave  bus
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BBW = $clog2(BLINK_CYCLES);
  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{ACTIVE_LOW}};
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BBW-1:0] BL_LAST = BBW'(BLINK_CYCLES - 1);

  logic [NUM_CH-1:0] sync1, sync2, stable, stable_d;
  logic [DBW-1:0]    db_cnt    [NUM_CH];
  logic [DBW-1:0]    db_cnt_nx [NUM_CH];
  logic [NUM_CH-1:0] stable_nx;
  logic [NUM_CH-1:0] led_state, led_state_nx;
  logic [NUM_CH-1:0] press, state, led;
  logic [NUM_CH-1:0] led_nx;
  logic [NUM_CH-1:0] pressed_now, pressed_prev, press_ev;
  logic [NUM_CH-1:0] onehot;
  logic              found;
  logic [BBW-1:0]    blink_cnt, blink_cnt_nx;
  logic              blink_phase, blink_phase_nx;

  assign bus.o_PRESS = press;
  assign bus.o_STATE = state;
  assign bus.o_LED   = led;

  // Polarity-normalised debounced level and the idle-to-pressed edge of it.
  always_comb begin
    pressed_now  = stable ^ IDLE;
    pressed_prev = stable_d ^ IDLE;
    press_ev     = pressed_now & ~pressed_prev;
  end

  // Debounce: accept sync2 after DEBOUNCE_CYCLES consecutive mismatching edges.
  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      db_cnt_nx[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nx[i] = sync2[i];
        end else begin
          db_cnt_nx[i] = db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // LED state update on press events; exclusive mode resolves to the lowest channel.
  always_comb begin
    led_state_nx = led_state;
    onehot       = '0;
    found        = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (press_ev[i] && !found) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
      end
    end
    case (bus.i_MODE)
      2'b01: led_state_nx = led_state;
      2'b11: begin
        if (found) begin
          led_state_nx = (led_state == onehot) ? '0 : onehot;
        end
      end
      default: led_state_nx = led_state ^ press_ev;
    endcase
  end

  // Free-running blink timebase; phase flips every BLINK_CYCLES edges.
  always_comb begin
    blink_cnt_nx   = blink_cnt + BBW'(1);
    blink_phase_nx = blink_phase;
    if (blink_cnt == BL_LAST) begin
      blink_cnt_nx   = '0;
      blink_phase_nx = ~blink_phase;
    end
  end

  // LED decode from next-state values so every output stays a plain register.
  always_comb begin
    case (bus.i_MODE)
      2'b01:   led_nx = pressed_now;
      2'b10:   led_nx = led_state_nx & {NUM_CH{blink_phase_nx}};
      default: led_nx = led_state_nx;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1       <= IDLE;
      sync2       <= IDLE;
      stable      <= IDLE;
      stable_d    <= IDLE;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        db_cnt[i] <= '0;
      end
      led_state   <= '0;
      press       <= '0;
      state       <= '0;
      led         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      sync1       <= bus.i_BUT;
      sync2       <= sync1;
      stable      <= stable_nx;
      stable_d    <= stable;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        db_cnt[i] <= db_cnt_nx[i];
      end
      led_state   <= led_state_nx;
      press       <= press_ev;
      state       <= pressed_now;
      led         <= led_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
    end
  end

endmodule
